// File: rtl/hybrid_adder_seq_if.sv
// Handshake and operand/result bundle for the block-serial hybrid adder.
interface hybrid_adder_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             ovf;

  modport master (
    output start, sub, x, y, c_in,
    input  busy, done, s, c_out, ovf
  );

  modport slave (
    input  start, sub, x, y, c_in,
    output busy, done, s, c_out, ovf
  );
endinterface

// File: rtl/hybrid_adder_seq.sv
// Block-serial add/subtract: one BLOCK-bit carry-lookahead slice per clock,
// with the inter-slice carry held in a register.

// One lookahead slice. Every carry is a flat generate/propagate sum of
// products over the slice, so no carry depends on a neighbouring carry gate.
module hybrid_cla_slice #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] sum,
  output logic             co,
  output logic             c_msb
);
  logic [BLOCK-1:0] g, p;
  logic [BLOCK:0]   c;
  logic             t, term;

  // Slice-level lookahead: c[i+1] = G[i:0] | P[i:0] & ci, expanded per bit.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    t    = 1'b0;
    term = 1'b0;
    c[0] = ci;
    for (int i = 0; i < BLOCK; i++) begin
      t = ci;
      for (int k = 0; k <= i; k++) t = t & p[k];
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int k = j + 1; k <= i; k++) term = term & p[k];
        t = t | term;
      end
      c[i+1] = t;
    end
  end

  assign sum   = p ^ c[BLOCK-1:0];
  assign co    = c[BLOCK];
  assign c_msb = c[BLOCK-1];
endmodule

module hybrid_adder_seq #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input logic               clk,
  input logic               rst_n,
  hybrid_adder_seq_if.slave bus
);
  localparam int NBLK = WIDTH / BLOCK;
  localparam int CW   = (NBLK > 1) ? $clog2(NBLK) : 1;

  generate
    if (WIDTH % BLOCK != 0) begin : g_bad_block
      $error("hybrid_adder_seq: BLOCK must divide WIDTH exactly");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic             cy_q, c_out_q, ovf_q, done_q;
  logic             accept, last;

  logic [BLOCK-1:0] sl_a, sl_b, sl_sum;
  logic             sl_co, sl_cmsb;

  assign sl_a = a_q[int'(cnt_q)*BLOCK +: BLOCK];
  assign sl_b = b_q[int'(cnt_q)*BLOCK +: BLOCK];

  hybrid_cla_slice #(.BLOCK(BLOCK)) u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .ci   (cy_q),
    .sum  (sl_sum),
    .co   (sl_co),
    .c_msb(sl_cmsb)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: accept start only when idle, return to idle on the last slice.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        accept  = 1'b1;
        state_d = RUN;
      end
      RUN: if (cnt_q == CW'(NBLK - 1)) begin
        last    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, slice write-back, carry register and result flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= last;
      if (accept) begin
        a_q     <= bus.x;
        b_q     <= bus.sub ? ~bus.y : bus.y;
        cy_q    <= bus.sub ? 1'b1 : bus.c_in;
        s_q     <= '0;
        c_out_q <= 1'b0;
        ovf_q   <= 1'b0;
        cnt_q   <= '0;
      end else if (state_q == RUN) begin
        s_q[int'(cnt_q)*BLOCK +: BLOCK] <= sl_sum;
        cy_q  <= sl_co;
        cnt_q <= last ? '0 : cnt_q + 1'b1;
        if (last) begin
          c_out_q <= sl_co;
          ovf_q   <= sl_cmsb ^ sl_co;
        end
      end
    end
  end

  assign bus.busy  = (state_q == RUN);
  assign bus.done  = done_q;
  assign bus.s     = s_q;
  assign bus.c_out = c_out_q;
  assign bus.ovf   = ovf_q;
endmodule
